mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store sequencer between the execute stage and Data_Memory_main (64 x 16b, registered read).
//  Accepts one load or store request per transaction over a valid/ready handshake and drives the memory strobes.
//  Waits out the memory's one-cycle registered read latency, then returns a held response to the writeback stage.
//  Asserts busy so the core stalls while a transaction is in flight.
// PARAMETERS
//  DATA_W     16  data word width
//  ADDR_W     16  request address width (ALU result)
//  MEM_AW     6   data-memory address width
//  MEM_DEPTH  64  number of implemented words; bound for the range check
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  req_valid    in   1       request present
//  req_ready    out  1       unit can accept; high only in IDLE
//  req_we       in   1       1 = store, 0 = load
//  req_addr     in   ADDR_W  word address
//  req_wdata    in   DATA_W  store data
//  rsp_valid    out  1       response present; held until rsp_ready
//  rsp_ready    in   1       consumer accepts response
//  rsp_rdata    out  DATA_W  load data; 0 for stores and faults
//  rsp_fault    out  1       out-of-range access; tied 0 without the macro
//  busy         out  1       state != IDLE
//  mem_wr_en    out  1       to memory wr_en
//  mem_rd_en    out  1       to memory rd_en
//  mem_address  out  MEM_AW  to memory mem_address
//  mem_data_in  out  DATA_W  to memory data_in
//  mem_data_out in   DATA_W  from memory data_out
// BEHAVIOUR
//  States: IDLE, ISSUE, LOAD_WAIT, RESP. Reset (sync, rst=1 at edge) -> IDLE.
//   Reset values: all outputs 0 except req_ready=1; addr_q/wdata_q/we_q/rdata_q cleared.
//  IDLE: req_ready=1. On req_valid at the edge: capture we, addr[MEM_AW-1:0], wdata. Go to ISSUE.
//  ISSUE: mem_address=addr_q, mem_data_in=wdata_q (held stable).
//   Store: mem_wr_en=1. Next state is RESP.
//   Load: mem_rd_en=1. Next state is LOAD_WAIT.
//   Never assert both strobes.
//  LOAD_WAIT: rdata_q <= mem_data_out at the edge. Next state is RESP.
//  RESP: rsp_valid=1; rsp_rdata=rdata_q (0 for a store); rsp_fault=fault_q.
//   rsp_ready=1 at the edge -> IDLE; otherwise hold all response outputs unchanged.
//  Latency (accept at edge N):
//   store write lands at edge N+1, rsp_valid from cycle N+2;
//   load rsp_valid from cycle N+3.
//   Back-to-back throughput with rsp_ready tied high: store every 3 cycles, load every 4.
//  Strobes are decoded from state and gated with !rst, so no memory write occurs in a cycle where rst=1.
//  Reset mid-transaction: the transaction is dropped, no response is produced, and the next cycle is IDLE.
//  req_valid outside IDLE is ignored (no capture). Request signals need not be held after acceptance.
//  The memory keeps its read data between reads; this unit always re-reads and never caches.
// CONFIGURATION
//  MAU_BOUNDS_CHECK_EN defined:
//   In IDLE, on acceptance, req_addr >= MEM_DEPTH sets fault_q=1 and the next state is RESP directly (no strobes).
//   The response is rsp_fault=1, rsp_rdata=0 for both loads and stores.
//  MAU_BOUNDS_CHECK_EN undefined:
//   Upper address bits are ignored and the address wraps modulo MEM_DEPTH (e.g. 0x0041 -> word 1).
//   rsp_fault is constant 0.
// TESTING
//  Store 0xBEEF @0x0005, rsp_ready=1 -> mem_wr_en high exactly 1 cycle with addr 5; rsp_valid at N+2, rdata 0.
//  Load @0x0005 after the above -> mem_rd_en 1 cycle; rsp_valid at N+3 with rsp_rdata=0xBEEF; busy high N+1..N+3.
//  Load with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata held stable; req_ready=0 throughout; IDLE after ready.
//  rst=1 during ISSUE of a store 0x1234 @3 -> no write (later load @3 returns prior value); no rsp_valid; IDLE next.
//  Store 0xAAAA @0x0041:
//   with MAU_BOUNDS_CHECK_EN -> no strobe, rsp_fault=1;
//   without it -> word 1 written, and a load @1 returns 0xAAAA.
//  req_valid held high in non-IDLE states -> exactly one capture per transaction, no lost or duplicated access.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory bus bundle for mem_access_unit
interface mem_access_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 6
);
  // execute-stage request
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  // writeback-stage response
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;
  // core stall
  logic              busy;
  // data memory port
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  // unit side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy,
           mem_wr_en, mem_rd_en, mem_address, mem_data_in
  );

  // core / memory environment side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy,
           mem_wr_en, mem_rd_en, mem_address, mem_data_in
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer for Data_Memory_main; optional MAU_BOUNDS_CHECK_EN range check
module mem_access_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_AW    = 6,
  parameter int MEM_DEPTH = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mem_access_unit_if.slave     bus
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_LOAD_WAIT = 2'd2;
  localparam logic [1:0] S_RESP      = 2'd3;

`ifdef MAU_BOUNDS_CHECK_EN
  localparam logic L_BOUNDS_EN = 1'b1;
`else
  localparam logic L_BOUNDS_EN = 1'b0;
`endif

  logic [1:0]        r_state;
  logic              r_we;
  logic [MEM_AW-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_fault;

  logic w_addr_oob;
  logic w_fault;
  logic w_issue;

  // Without the range check the compare is masked off, so upper address
  // bits simply fall away and the word address wraps modulo MEM_DEPTH.
  assign w_addr_oob = (bus.req_addr >= ADDR_W'(MEM_DEPTH));
  assign w_fault    = L_BOUNDS_EN & w_addr_oob;

  // Strobes come from state but are killed while rst is high so a reset
  // landing in ISSUE can never write the memory.
  assign w_issue = (r_state == S_ISSUE) && !i_rst;

  // Transaction sequencer: capture in IDLE, strobe in ISSUE, sample read
  // data in LOAD_WAIT, hold the response in RESP until it is taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr[MEM_AW-1:0];
            r_wdata <= bus.req_wdata;
            r_rdata <= '0;
            r_fault <= w_fault;
            r_state <= w_fault ? S_RESP : S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= r_we ? S_RESP : S_LOAD_WAIT;
        end
        S_LOAD_WAIT: begin
          r_rdata <= bus.mem_data_out;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.rsp_valid   = (r_state == S_RESP);
  assign bus.rsp_rdata   = r_rdata;
  assign bus.rsp_fault   = r_fault;
  assign bus.mem_wr_en   = w_issue & r_we;
  assign bus.mem_rd_en   = w_issue & ~r_we;
  assign bus.mem_address = r_addr;
  assign bus.mem_data_in = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a 64x16 registered-read memory model
module tb_mem_access_unit;

  logic i_clk = 1'b0;
  logic i_rst;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_access_unit_if #(.DATA_W(16), .ADDR_W(16), .MEM_AW(6)) bus ();

  mem_access_unit #(
    .DATA_W(16), .ADDR_W(16), .MEM_AW(6), .MEM_DEPTH(64)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  // Data_Memory_main model: synchronous write, registered read that holds.
  logic [15:0] mem [64];
  logic [15:0] mem_dout = '0;
  assign bus.mem_data_out = mem_dout;
  always @(posedge i_clk) begin
    if (bus.mem_wr_en) mem[bus.mem_address] <= bus.mem_data_in;
    if (bus.mem_rd_en) mem_dout <= mem[bus.mem_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // One transaction with rsp_ready high; counts strobes and measures the
  // number of cycles from acceptance to the first visible rsp_valid.
  task automatic run_txn(input string tag, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic hold,
                         input int exp_lat, input int exp_wr, input int exp_rd,
                         input logic [5:0] exp_maddr, input logic [15:0] exp_rdata,
                         input logic exp_fault);
    int k = 1;
    int n_wr = 0;
    int n_rd = 0;
    logic [5:0] seen_addr = '0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = 1'b1;
    step();
    if (!hold) bus.req_valid = 1'b0;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wdata;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    while (!bus.rsp_valid && k < 8) begin
      if (bus.mem_wr_en || bus.mem_rd_en) seen_addr = bus.mem_address;
      n_wr += int'(bus.mem_wr_en);
      n_rd += int'(bus.mem_rd_en);
      step();
      k++;
    end
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_wr_pulses"}, 32'(n_wr), 32'(exp_wr));
    check({tag, "_rd_pulses"}, 32'(n_rd), 32'(exp_rd));
    if (exp_wr + exp_rd > 0) check({tag, "_mem_addr"}, 32'(seen_addr), 32'(exp_maddr));
    check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
    check({tag, "_fault"}, 32'(bus.rsp_fault), 32'(exp_fault));
    bus.req_valid = 1'b0;
    step();
    check({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    i_rst         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_fault", 32'(bus.rsp_fault), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_address), 32'd0);

    run_txn("st3", 1'b1, 16'h0003, 16'h5A5A, 1'b0, 2, 1, 0, 6'd3, 16'h0000, 1'b0);
    run_txn("st5", 1'b1, 16'h0005, 16'hBEEF, 1'b0, 2, 1, 0, 6'd5, 16'h0000, 1'b0);
    run_txn("ld5", 1'b0, 16'h0005, 16'h0000, 1'b0, 3, 0, 1, 6'd5, 16'hBEEF, 1'b0);
    run_txn("ld3", 1'b0, 16'h0003, 16'h0000, 1'b0, 3, 0, 1, 6'd3, 16'h5A5A, 1'b0);

    // Response held while the consumer stalls.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0005;
    bus.rsp_ready = 1'b0;
    step();
    bus.req_valid = 1'b0;
    k = 1;
    while (!bus.rsp_valid && k < 8) begin
      step();
      k++;
    end
    check("hold_latency", 32'(k), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rdata", 32'(bus.rsp_rdata), 32'hBEEF);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    check("hold_release_ready", 32'(bus.req_ready), 32'd1);
    check("hold_release_valid", 32'(bus.rsp_valid), 32'd0);

    // Reset while a store sits in ISSUE: strobe must drop, nothing written.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 16'h0003;
    bus.req_wdata = 16'h1234;
    step();
    bus.req_valid = 1'b0;
    check("mid_rst_issue_wr", 32'(bus.mem_wr_en), 32'd1);
    i_rst = 1'b1;
    #1;
    check("mid_rst_gated_wr", 32'(bus.mem_wr_en), 32'd0);
    step();
    i_rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    step();
    check("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    run_txn("ld3_after_rst", 1'b0, 16'h0003, 16'h0000, 1'b0, 3, 0, 1, 6'd3, 16'h5A5A, 1'b0);

`ifdef MAU_BOUNDS_CHECK_EN
    run_txn("st41_fault", 1'b1, 16'h0041, 16'hAAAA, 1'b0, 1, 0, 0, 6'd0, 16'h0000, 1'b1);
    run_txn("ld41_fault", 1'b0, 16'h0041, 16'h0000, 1'b0, 1, 0, 0, 6'd0, 16'h0000, 1'b1);
    run_txn("ld5_after_fault", 1'b0, 16'h0005, 16'h0000, 1'b0, 3, 0, 1, 6'd5, 16'hBEEF, 1'b0);
`else
    run_txn("st41_wrap", 1'b1, 16'h0041, 16'hAAAA, 1'b0, 2, 1, 0, 6'd1, 16'h0000, 1'b0);
    run_txn("ld1_wrap", 1'b0, 16'h0001, 16'h0000, 1'b0, 3, 0, 1, 6'd1, 16'hAAAA, 1'b0);
`endif

    // req_valid held high through the whole transaction: one capture only.
    run_txn("st7_held", 1'b1, 16'h0007, 16'h1111, 1'b1, 2, 1, 0, 6'd7, 16'h0000, 1'b0);
    run_txn("ld7_held", 1'b0, 16'h0007, 16'h0000, 1'b1, 3, 0, 1, 6'd7, 16'h1111, 1'b0);
    run_txn("ld5_final", 1'b0, 16'h0005, 16'h0000, 1'b0, 3, 0, 1, 6'd5, 16'hBEEF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
